// File: rtl/kbd_matrix_scan.sv
// ============================================================================
// Module      : kbd_matrix_scan
// Description : Queues PS/2 scan events, translates them through an external
//               keymap ROM and maintains an active-low PPI key matrix.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kbd_matrix_scan #(
    parameter int ROWS       = 11,
    parameter int COLS       = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int LAYER_W    = 1,
    parameter int RW         = $clog2(ROWS),
    parameter int CW         = $clog2(COLS),
    parameter int PW         = $clog2(ROWS*COLS+1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_ena,
    input  logic [10:0]          ps2_key,
    input  logic [LAYER_W-1:0]   layout,
    input  logic                 clear,
    output logic [LAYER_W+8:0]   map_addr,
    input  logic [RW+CW:0]       map_data,
    input  logic [RW-1:0]        row_sel,
    output logic [COLS-1:0]      col_n,
    output logic [PW-1:0]        pressed_count,
    output logic                 busy,
    output logic                 overflow
);

    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   c_depth = (AW+1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] c_max   = PW'(ROWS*COLS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_APPLY  = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_brk;
    logic [9:0]        r_fifo [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_fifo_cnt;
    logic [COLS-1:0]   r_matrix [ROWS];

    logic              w_empty, w_full;
    logic              w_pop, w_push, w_drop;
    logic [9:0]        w_head;
    logic              w_map_valid;
    logic [RW-1:0]     w_map_row;
    logic [CW-1:0]     w_map_col;
    logic              w_row_ok, w_col_ok;
    logic [COLS-1:0]   w_cur_row;
    logic              w_cur_bit;
    logic [COLS-1:0]   w_read_row;
    logic              w_apply, w_set, w_clr;

    assign w_empty = (r_fifo_cnt == '0);
    assign w_full  = (r_fifo_cnt == c_depth);
    assign w_head  = r_fifo[r_rd_ptr];

    // A pop in the same clk frees a slot, so a strobe on a full queue still lands.
    assign w_pop  = clk_ena && (r_state == S_IDLE) && !w_empty && !clear;
    assign w_push = ps2_key[10] && (!w_full || w_pop) && !clear;
    assign w_drop = ps2_key[10] && w_full && !w_pop && !clear;

    assign busy = (r_state != S_IDLE) || !w_empty;

    assign w_map_valid = map_data[RW+CW];
    assign w_map_row   = map_data[RW+CW-1:CW];
    assign w_map_col   = map_data[CW-1:0];

    // Row/column decode by match keeps out-of-range ROM entries harmless.
    always_comb begin
        w_row_ok   = 1'b0;
        w_col_ok   = 1'b0;
        w_cur_row  = '0;
        w_cur_bit  = 1'b0;
        w_read_row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (w_map_row == RW'(r)) begin
                w_row_ok  = 1'b1;
                w_cur_row = r_matrix[r];
            end
            if (row_sel == RW'(r)) begin
                w_read_row = r_matrix[r];
            end
        end
        for (int c = 0; c < COLS; c++) begin
            if (w_map_col == CW'(c)) begin
                w_col_ok  = 1'b1;
                w_cur_bit = w_cur_row[c];
            end
        end
    end

    assign w_apply = clk_ena && (r_state == S_APPLY) && !clear &&
                     w_map_valid && w_row_ok && w_col_ok;
    assign w_set   = w_apply && !r_brk && !w_cur_bit;
    assign w_clr   = w_apply &&  r_brk &&  w_cur_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            overflow   <= 1'b0;
        end else if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            overflow   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + (AW+1)'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - (AW+1)'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
            if (w_drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_fifo[r_wr_ptr] <= ps2_key[9:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_brk    <= 1'b0;
            map_addr <= '0;
        end else if (clear) begin
            r_state  <= S_IDLE;
        end else if (clk_ena) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_brk    <= w_head[9];
                        map_addr <= {layout, w_head[8:0]};
                        r_state  <= S_LOOKUP;
                    end
                end
                S_LOOKUP: r_state <= S_APPLY;
                S_APPLY:  r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int r = 0; r < ROWS; r++) begin
                r_matrix[r] <= '0;
            end
            pressed_count <= '0;
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if ((w_map_row == RW'(r)) && (w_map_col == CW'(c))) begin
                        if (w_set)      r_matrix[r][c] <= 1'b1;
                        else if (w_clr) r_matrix[r][c] <= 1'b0;
                    end
                end
            end
            if (w_set && (pressed_count != c_max))
                pressed_count <= pressed_count + PW'(1);
            else if (w_clr && (pressed_count != '0))
                pressed_count <= pressed_count - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) col_n <= '1;
        else       col_n <= ~w_read_row;
    end

endmodule

`default_nettype wire

// File: tb/tb_kbd_matrix_scan.sv
// ============================================================================
// Module      : tb_kbd_matrix_scan
// Description : Directed and randomized self-checking bench for kbd_matrix_scan.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_kbd_matrix_scan;

    localparam int ROWS       = 11;
    localparam int COLS       = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int LAYER_W    = 1;
    localparam int RW         = 4;
    localparam int CW         = 3;
    localparam int PW         = 7;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 clk_ena;
    logic [10:0]          ps2_key;
    logic [LAYER_W-1:0]   layout;
    logic                 clear;
    logic [LAYER_W+8:0]   map_addr;
    logic [RW+CW:0]       map_data;
    logic [RW-1:0]        row_sel;
    logic [COLS-1:0]      col_n;
    logic [PW-1:0]        pressed_count;
    logic                 busy;
    logic                 overflow;

    logic [7:0] rom [1024];
    int n_cmp = 0;
    int n_mis = 0;

    bit  m_key [ROWS][COLS];
    bit  m_ovf;

    kbd_matrix_scan #(
        .ROWS(ROWS), .COLS(COLS), .FIFO_DEPTH(FIFO_DEPTH), .LAYER_W(LAYER_W)
    ) dut (
        .clk(clk), .reset(reset), .clk_ena(clk_ena), .ps2_key(ps2_key),
        .layout(layout), .clear(clear), .map_addr(map_addr), .map_data(map_data),
        .row_sel(row_sel), .col_n(col_n), .pressed_count(pressed_count),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Registered keymap ROM, one clk of latency
    always @(posedge clk) map_data <= rom[map_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit brk, input bit ext, input logic [7:0] code);
        ps2_key = {1'b1, brk, ext, code};
        step();
        ps2_key = '0;
    endtask

    task automatic wait_idle(input string tag);
        int i = 0;
        while (busy && i < 300) begin
            step();
            i++;
        end
        chk(tag, 32'(busy), 32'd0);
        step();
        step();
    endtask

    function automatic int m_count();
        int s = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                s += int'(m_key[r][c]);
        return s;
    endfunction

    task automatic m_apply(input bit brk, input bit ext, input logic [7:0] code,
                           input logic [LAYER_W-1:0] lay);
        logic [7:0] d;
        d = rom[{lay, ext, code}];
        if (d[7] && (int'(d[6:3]) < ROWS))
            m_key[d[6:3]][d[2:0]] = !brk;
    endtask

    task automatic check_matrix(input string tag);
        logic [7:0] exp;
        for (int r = 0; r < 16; r++) begin
            row_sel = RW'(r);
            step();
            exp = 8'hFF;
            if (r < ROWS)
                for (int c = 0; c < COLS; c++)
                    if (m_key[r][c]) exp[c] = 1'b0;
            chk(tag, 32'(col_n), 32'(exp));
        end
    endtask

    initial begin : main
        logic [9:0] q[$];
        logic [9:0] ev;
        int n, gap, it;
        logic [LAYER_W-1:0] lay;

        for (int a = 0; a < 1024; a++) rom[a] = 8'($urandom);
        rom[10'h01C] = {1'b1, 4'd2, 3'd6};
        rom[10'h032] = {1'b1, 4'd3, 3'd2};
        rom[10'h021] = {1'b1, 4'd2, 3'd1};
        rom[10'h040] = {1'b0, 4'd2, 3'd0};
        rom[10'h041] = {1'b1, 4'd12, 3'd0};
        for (int k = 0; k < 5; k++) rom[10'h050 + 10'(k)] = {1'b1, 4'd4, 3'(k)};

        reset = 1'b1; clk_ena = 1'b0; ps2_key = '0; layout = '0; clear = 1'b0; row_sel = '0;
        step(); step(); step();
        reset = 1'b0;
        chk("rst_col_n", 32'(col_n), 32'hFF);
        chk("rst_map_addr", 32'(map_addr), 32'd0);
        chk("rst_count", 32'(pressed_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // Single make: latency and active-low readback
        clk_ena = 1'b1; row_sel = 4'd2;
        send(1'b0, 1'b0, 8'h1C);
        chk("strobe_busy", 32'(busy), 32'd1);
        step(); step(); step();
        chk("lat_early_col", 32'(col_n), 32'hFF);
        chk("lat_count", 32'(pressed_count), 32'd1);
        step();
        chk("lat_col", 32'(col_n), 32'hBF);
        send(1'b1, 1'b0, 8'h1C);
        wait_idle("brk_idle");
        chk("brk_col", 32'(col_n), 32'hFF);
        chk("brk_count", 32'(pressed_count), 32'd0);

        // Three back-to-back makes
        ps2_key = {3'b100, 8'h1C}; step();
        ps2_key = {3'b100, 8'h32}; step();
        ps2_key = {3'b100, 8'h21}; step();
        ps2_key = '0;
        for (int k = 0; k < 8; k++) step();
        chk("b2b_count", 32'(pressed_count), 32'd3);
        chk("b2b_ovf", 32'(overflow), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd0);
        row_sel = 4'd2; step();
        chk("b2b_row2", 32'(col_n), 32'hBD);
        row_sel = 4'd3; step();
        chk("b2b_row3", 32'(col_n), 32'hFB);
        clear = 1'b1; step(); clear = 1'b0;
        chk("clr_count", 32'(pressed_count), 32'd0);

        // Overflow with FSM frozen
        clk_ena = 1'b0;
        for (int k = 0; k < 5; k++) send(1'b0, 1'b0, 8'h50 + 8'(k));
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_busy", 32'(busy), 32'd1);
        step(); step();
        chk("ovf_frozen", 32'(pressed_count), 32'd0);
        clk_ena = 1'b1;
        wait_idle("ovf_idle");
        chk("ovf_applied", 32'(pressed_count), 32'd4);
        row_sel = 4'd4; step();
        chk("ovf_row4", 32'(col_n), 32'hF0);

        // Invalid and out-of-range map entries
        send(1'b0, 1'b0, 8'h40);
        wait_idle("inv_idle");
        send(1'b0, 1'b0, 8'h41);
        wait_idle("row12_idle");
        chk("inv_count", 32'(pressed_count), 32'd4);
        row_sel = 4'd2; step();
        chk("inv_row2", 32'(col_n), 32'hFF);

        // Typematic repeat and break of an unpressed key
        send(1'b0, 1'b0, 8'h1C);
        send(1'b0, 1'b0, 8'h1C);
        send(1'b0, 1'b0, 8'h1C);
        wait_idle("rep_idle");
        chk("rep_count", 32'(pressed_count), 32'd5);
        send(1'b1, 1'b0, 8'h54);
        wait_idle("brk_unp_idle");
        chk("brk_unp_count", 32'(pressed_count), 32'd5);

        // Clear colliding with a strobe
        ps2_key = {3'b100, 8'h32}; clear = 1'b1;
        step();
        ps2_key = '0; clear = 1'b0;
        chk("clr_s_count", 32'(pressed_count), 32'd0);
        chk("clr_s_ovf", 32'(overflow), 32'd0);
        chk("clr_s_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 6; k++) step();
        chk("clr_s_late", 32'(pressed_count), 32'd0);
        row_sel = 4'd3; step();
        chk("clr_s_row3", 32'(col_n), 32'hFF);

        // Randomized rounds against the matrix model
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                m_key[r][c] = 1'b0;
        m_ovf = 1'b0;
        for (int rd = 0; rd < 40; rd++) begin
            q.delete();
            lay = LAYER_W'($urandom_range(0, 1));
            layout = lay;
            clk_ena = 1'b0;
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                ev = {1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                      8'($urandom_range(0, 31))};
                if (k < FIFO_DEPTH) q.push_back(ev);
                send(ev[9], ev[8], ev[7:0]);
                gap = $urandom_range(0, 1);
                for (int g = 0; g < gap; g++) step();
            end
            if (n > FIFO_DEPTH) m_ovf = 1'b1;
            it = 0;
            while (busy && it < 400) begin
                clk_ena = ($urandom_range(0, 3) != 0);
                step();
                it++;
            end
            clk_ena = 1'b1;
            chk("rnd_idle", 32'(busy), 32'd0);
            step(); step();
            foreach (q[i]) m_apply(q[i][9], q[i][8], q[i][7:0], lay);
            chk("rnd_count", 32'(pressed_count), 32'(m_count()));
            chk("rnd_ovf", 32'(overflow), 32'(m_ovf));
            check_matrix("rnd_col_n");
            if ($urandom_range(0, 5) == 0) begin
                clear = 1'b1; step(); clear = 1'b0;
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++)
                        m_key[r][c] = 1'b0;
                m_ovf = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
